// File: rtl/fftconv_pkg.sv
// Shared constants and helpers for the FFT-conv output stage: default sizes,
// complex-word real/imag extraction and signed saturation.
package fftconv_pkg;

  localparam int DATALEN_DEF = 16;
  localparam int FFTCHNL_DEF = 8;
  localparam int KSIZE_DEF   = 3;
  localparam int OUTW_DEF    = FFTCHNL_DEF - KSIZE_DEF + 1;
  localparam int BEATS_DEF   = FFTCHNL_DEF / 2;

  // Complex word is {real, imag}; dl is the component width. Result is sign-extended.
  function automatic logic signed [63:0] cplx_real(input logic [127:0] word, input int dl);
    logic [127:0]       s;
    logic signed [63:0] r;
    s = word >> dl;
    r = $signed(s[63:0]) <<< (64 - dl);
    return r >>> (64 - dl);
  endfunction

  function automatic logic signed [63:0] cplx_imag(input logic [127:0] word, input int dl);
    logic signed [63:0] r;
    r = $signed(word[63:0]) <<< (64 - dl);
    return r >>> (64 - dl);
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x, input int w);
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (w - 1));
    if (x > mx) return mx;
    if (x < mn) return mn;
    return x;
  endfunction

endpackage

// File: rtl/fftconv_row_fifo.sv
// Row FIFO with up to two writes and one read per cycle; head data reads as
// zero while empty. Writers must respect o_count (no internal overflow guard).
module fftconv_row_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_wr0,
  input  logic          i_wr1,
  input  logic [W-1:0]  i_wd0,
  input  logic [W-1:0]  i_wd1,
  input  logic          i_rd,
  output logic [W-1:0]  o_data,
  output logic          o_vld,
  output logic [CW-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_rd;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_rd    = i_rd && (r_cnt != '0);
  assign o_vld   = (r_cnt != '0);
  assign o_count = r_cnt;
  assign o_data  = o_vld ? r_mem[r_rp] : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_rd) r_rp <= nxt(r_rp);
      if (i_wr0 && i_wr1)      r_wp <= nxt(nxt(r_wp));
      else if (i_wr0 || i_wr1) r_wp <= nxt(r_wp);
      r_cnt <= r_cnt + CW'(i_wr0) + CW'(i_wr1) - CW'(w_rd);
    end
  end

  // Second row lands behind the first, or at the write pointer if it is alone.
  always_ff @(posedge clk) begin
    if (i_wr0) r_mem[r_wp] <= i_wd0;
    if (i_wr1) r_mem[i_wr0 ? nxt(r_wp) : r_wp] <= i_wd1;
  end

endmodule

// File: rtl/fftconv_outstage.sv
// IFFT output stage: real part, overlap-save crop, round/shift, bias, optional
// ReLU (FFTCONV_OUTSTAGE_RELU_EN), saturate, then row FIFO with valid/ready.
module fftconv_outstage import fftconv_pkg::*; #(
  parameter int DATALEN = DATALEN_DEF,
  parameter int FFTCHNL = FFTCHNL_DEF,
  parameter int COUT    = 2,
  parameter int KSIZE   = KSIZE_DEF,
  parameter int SHIFT   = 6,
  parameter int DEPTH   = 8
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [COUT-1:0]                     invalid,
  input  logic [COUT*FFTCHNL*4*DATALEN-1:0]   indata,
  input  logic [COUT*DATALEN-1:0]             bias,
  output logic                                outvalid,
  input  logic                                outready,
  output logic [COUT*(FFTCHNL-KSIZE+1)*DATALEN-1:0] outdata,
  output logic                                outlast,
  output logic                                overflow,
  output logic                                lane_err
);

  localparam int OUTW  = FFTCHNL - KSIZE + 1;
  localparam int BEATS = FFTCHNL / 2;
  localparam int LANEW = FFTCHNL * 4 * DATALEN;
  localparam int ROWW  = COUT * OUTW * DATALEN;
  localparam int AW    = DATALEN + 2;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic signed [AW-1:0] RND = AW'((1 << SHIFT) >> 1);

  function automatic logic signed [DATALEN-1:0] lane_real(
    input logic [COUT*LANEW-1:0] d, input int lane, input int word);
    logic [2*DATALEN-1:0] w;
    logic signed [63:0]   x;
    w = d[lane*LANEW + word*2*DATALEN +: 2*DATALEN];
    x = cplx_real(128'(w), DATALEN);
    return x[DATALEN-1:0];
  endfunction

  function automatic logic signed [DATALEN-1:0] proc_val(
    input logic signed [DATALEN-1:0] re, input logic signed [DATALEN-1:0] bs);
    logic signed [AW-1:0] t;
    logic signed [63:0]   s;
    t = $signed({{2{re[DATALEN-1]}}, re}) + RND;
    t = t >>> SHIFT;
    t = t + $signed({{2{bs[DATALEN-1]}}, bs});
`ifdef FFTCONV_OUTSTAGE_RELU_EN
    if (t < 0) t = '0;
`endif
    s = sat_signed({{(64-AW){t[AW-1]}}, t}, DATALEN);
    return s[DATALEN-1:0];
  endfunction

  logic [BW-1:0]   r_b;
  logic            w_beat;
  logic            w_keep0;
  logic            w_keep1;
  logic            w_last;
  logic [ROWW-1:0] w_row0;
  logic [ROWW-1:0] w_row1;
  logic            w_unused_in;

  assign w_unused_in = ^indata;

  always_comb begin
    w_beat  = invalid[0];
    w_keep0 = (2 * int'(r_b) >= KSIZE - 1);
    w_keep1 = (2 * int'(r_b) + 1 >= KSIZE - 1);
    w_last  = (int'(r_b) == BEATS - 1);
    w_row0  = '0;
    w_row1  = '0;
    for (int i = 0; i < COUT; i++) begin
      for (int k = 0; k < OUTW; k++) begin
        w_row0[(i*OUTW+k)*DATALEN +: DATALEN] =
          proc_val(lane_real(indata, i, k + KSIZE - 1), bias[i*DATALEN +: DATALEN]);
        w_row1[(i*OUTW+k)*DATALEN +: DATALEN] =
          proc_val(lane_real(indata, i, FFTCHNL + k + KSIZE - 1), bias[i*DATALEN +: DATALEN]);
      end
    end
  end

  // Stage p0: arithmetic register; beat counter and sticky flags
  logic            r_vld_p0;
  logic            r_keep0_p0;
  logic            r_keep1_p0;
  logic            r_last_p0;
  logic [ROWW-1:0] r_row0_p0;
  logic [ROWW-1:0] r_row1_p0;
  logic            r_overflow;
  logic            r_lane_err;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_b        <= '0;
      r_vld_p0   <= 1'b0;
      r_keep0_p0 <= 1'b0;
      r_keep1_p0 <= 1'b0;
      r_last_p0  <= 1'b0;
      r_lane_err <= 1'b0;
    end else begin
      r_vld_p0   <= w_beat;
      r_keep0_p0 <= w_keep0;
      r_keep1_p0 <= w_keep1;
      r_last_p0  <= w_last;
      if (w_beat) r_b <= (r_b == BW'(BEATS - 1)) ? '0 : r_b + 1'b1;
      if (invalid != '0 && invalid != '1) r_lane_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    r_row0_p0 <= w_row0;
    r_row1_p0 <= w_row1;
  end

  // Stage p1: FIFO write, all-or-nothing per beat against pre-read free space
  logic [CW-1:0]   w_cnt;
  logic            w_drop;
  logic            w_wr0;
  logic            w_wr1;
  logic [ROWW:0]   w_head;
  logic            w_fvld;

  always_comb begin
    w_drop = r_vld_p0 &&
             ((DEPTH - int'(w_cnt)) < (int'(r_keep0_p0) + int'(r_keep1_p0)));
    w_wr0  = r_vld_p0 && r_keep0_p0 && !w_drop;
    w_wr1  = r_vld_p0 && r_keep1_p0 && !w_drop;
  end

  always_ff @(posedge clk) begin
    if (!rstn)       r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  fftconv_row_fifo #(
    .W     (ROWW + 1),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_wr0   (w_wr0),
    .i_wr1   (w_wr1),
    .i_wd0   ({1'b0, r_row0_p0}),
    .i_wd1   ({r_last_p0, r_row1_p0}),
    .i_rd    (outready),
    .o_data  (w_head),
    .o_vld   (w_fvld),
    .o_count (w_cnt)
  );

  assign outvalid = w_fvld;
  assign outlast  = w_head[ROWW];
  assign outdata  = w_head[ROWW-1:0];
  assign overflow = r_overflow;
  assign lane_err = r_lane_err;

endmodule

// File: tb/tb_fftconv_outstage.sv
// Scoreboard bench for fftconv_outstage: stimulus pushes expected rows from a
// value-level model, a negedge monitor pops and compares on each transfer.
module tb_fftconv_outstage;

  localparam int DATALEN = 16;
  localparam int FFTCHNL = 8;
  localparam int COUT    = 2;
  localparam int KSIZE   = 3;
  localparam int SHIFT   = 6;
  localparam int DEPTH   = 8;
  localparam int OUTW    = FFTCHNL - KSIZE + 1;
  localparam int BEATS   = FFTCHNL / 2;
  localparam int LANEW   = FFTCHNL * 4 * DATALEN;
  localparam int ROWW    = COUT * OUTW * DATALEN;

  logic                    clk = 1'b0;
  logic                    rstn = 1'b0;
  logic [COUT-1:0]         invalid = '0;
  logic [COUT*LANEW-1:0]   indata = '0;
  logic [COUT*DATALEN-1:0] bias = '0;
  logic                    outvalid;
  logic                    outready = 1'b0;
  logic [ROWW-1:0]         outdata;
  logic                    outlast;
  logic                    overflow;
  logic                    lane_err;

  fftconv_outstage #(
    .DATALEN(DATALEN), .FFTCHNL(FFTCHNL), .COUT(COUT),
    .KSIZE(KSIZE), .SHIFT(SHIFT), .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .invalid  (invalid),
    .indata   (indata),
    .bias     (bias),
    .outvalid (outvalid),
    .outready (outready),
    .outdata  (outdata),
    .outlast  (outlast),
    .overflow (overflow),
    .lane_err (lane_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            last;
    logic [ROWW-1:0] data;
  } row_t;

  row_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_b = 0;
  int   re_v [COUT][2][FFTCHNL];
  int   im_v [COUT][2][FFTCHNL];
  int   bias_v [COUT];

  task automatic chk(input string nm, input logic [ROWW:0] act, input logic [ROWW:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Reference arithmetic straight from the value rules, using plain integers.
  function automatic int exp_val(input int re, input int bs);
    int t;
    t = re + ((1 << SHIFT) / 2);
    t = t >>> SHIFT;
    t = t + bs;
`ifdef FFTCONV_OUTSTAGE_RELU_EN
    if (t < 0) t = 0;
`endif
    if (t > (1 << (DATALEN-1)) - 1) t = (1 << (DATALEN-1)) - 1;
    if (t < -(1 << (DATALEN-1)))    t = -(1 << (DATALEN-1));
    return t;
  endfunction

  task automatic fill_const(input int re0, input int re1, input int im, input int b0, input int b1);
    for (int l = 0; l < COUT; l++)
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < FFTCHNL; c++) begin
          re_v[l][r][c] = (l == 0) ? re0 : re1;
          im_v[l][r][c] = im;
        end
    bias_v[0] = b0;
    bias_v[1] = b1;
  endtask

  task automatic fill_rand();
    for (int l = 0; l < COUT; l++) begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < FFTCHNL; c++) begin
          re_v[l][r][c] = int'($urandom_range(65535)) - 32768;
          im_v[l][r][c] = int'($urandom_range(65535)) - 32768;
        end
      bias_v[l] = int'($urandom_range(8191)) - 4096;
    end
  endtask

  // Drive one beat for one cycle and record what the sink should receive.
  task automatic send_beat(input logic [COUT-1:0] inv);
    row_t e [2];
    bit   keep [2];
    int   nk;
    logic [DATALEN-1:0] rr, ii;
    nk = 0;
    for (int l = 0; l < COUT; l++) begin
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < FFTCHNL; c++) begin
          rr = DATALEN'(re_v[l][r][c]);
          ii = DATALEN'(im_v[l][r][c]);
          indata[l*LANEW + (r*FFTCHNL+c)*2*DATALEN +: 2*DATALEN] = {rr, ii};
        end
      bias[l*DATALEN +: DATALEN] = DATALEN'(bias_v[l]);
    end
    for (int r = 0; r < 2; r++) begin
      keep[r] = (2*m_b + r >= KSIZE - 1);
      if (keep[r]) nk++;
      e[r].data = '0;
      e[r].last = (2*m_b + r == FFTCHNL - 1);
      for (int l = 0; l < COUT; l++)
        for (int k = 0; k < OUTW; k++)
          e[r].data[(l*OUTW+k)*DATALEN +: DATALEN] =
            DATALEN'(exp_val(re_v[l][r][k+KSIZE-1], bias_v[l]));
    end
    if (inv[0]) begin
      if (nk > 0 && exp_q.size() + nk <= DEPTH) begin
        for (int r = 0; r < 2; r++) if (keep[r]) exp_q.push_back(e[r]);
      end
      m_b = (m_b + 1) % BEATS;
    end
    invalid = inv;
    @(posedge clk); #1;
    invalid = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    exp_q.delete();
    m_b = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic drain(input string nm);
    outready = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk({nm, "_all_rows_seen"}, (ROWW+1)'(exp_q.size()), '0);
    chk({nm, "_idle_after"}, (ROWW+1)'(outvalid), '0);
  endtask

  // Monitor: compare every transfer and hold-stability under backpressure.
  initial begin
    bit   held;
    row_t held_v;
    row_t e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && outvalid) begin
        if (held) chk("hold_stable", {outlast, outdata}, held_v);
        if (outready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_row: got %h expected none", {outlast, outdata});
          end else begin
            e = exp_q.pop_front();
            chk("row", {outlast, outdata}, e);
          end
          held = 1'b0;
        end else begin
          held   = 1'b1;
          held_v = {outlast, outdata};
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    int w;
    logic [DATALEN-1:0] neg_exp;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outvalid", (ROWW+1)'(outvalid), '0);
    chk("rst_outlast", (ROWW+1)'(outlast), '0);
    chk("rst_outdata", (ROWW+1)'(outdata), '0);
    chk("rst_overflow", (ROWW+1)'(overflow), '0);
    chk("rst_lane_err", (ROWW+1)'(lane_err), '0);
    rstn = 1'b1;

    // Constant tile, back-to-back beats, latency of first kept row
    outready = 1'b1;
    fill_const(320, 320, 7, 0, 0);
    send_beat('1);
    send_beat('1);
    chk("lat_before", (ROWW+1)'(outvalid), '0);
    send_beat('1);
    chk("lat_at_2", (ROWW+1)'(outvalid), (ROWW+1)'(1));
    send_beat('1);
    drain("const_tile");

    // Rounding and saturation, inspected at the head under backpressure
    outready = 1'b0;
    fill_const(32767, -33, 0, 100, 0);
    repeat (BEATS) send_beat('1);
    @(posedge clk); #1;
`ifdef FFTCONV_OUTSTAGE_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'hFFFF;
`endif
    chk("round_sat_pos", (ROWW+1)'(outdata[0 +: DATALEN]), (ROWW+1)'(16'd612));
    chk("round_neg", (ROWW+1)'(outdata[OUTW*DATALEN +: DATALEN]), (ROWW+1)'(neg_exp));
    drain("round");

    // Two tiles against a stalled sink: later beats of tile 2 are dropped
    outready = 1'b0;
    repeat (2*BEATS) begin
      fill_rand();
      send_beat('1);
    end
    repeat (2) begin @(posedge clk); #1; end
    chk("bp_overflow", (ROWW+1)'(overflow), (ROWW+1)'(1));
    chk("bp_full_valid", (ROWW+1)'(outvalid), (ROWW+1)'(1));
    drain("backpressure");
    do_reset();
    chk("ovf_cleared", (ROWW+1)'(overflow), '0);

    // Gapped beats
    outready = 1'b1;
    repeat (BEATS) begin
      fill_rand();
      send_beat('1);
      repeat (3) begin @(posedge clk); #1; end
    end
    drain("gapped");

    // Reset one cycle after beat 2, then a clean tile
    outready = 1'b1;
    repeat (3) begin
      fill_rand();
      send_beat('1);
    end
    do_reset();
    chk("rst_mid_valid", (ROWW+1)'(outvalid), '0);
    repeat (BEATS) begin
      fill_rand();
      send_beat('1);
    end
    drain("after_rst");

    // Lane independence and lane_err
    chk("lane_err_clear", (ROWW+1)'(lane_err), '0);
    outready = 1'b0;
    fill_const(640, 640, 0, 10, -10);
    repeat (BEATS) send_beat('1);
    @(posedge clk); #1;
    chk("lane0_bias", (ROWW+1)'(outdata[0 +: DATALEN]), (ROWW+1)'(16'd20));
    chk("lane1_bias", (ROWW+1)'(outdata[OUTW*DATALEN +: DATALEN]), '0);
    drain("lanes");
    fill_rand();
    send_beat(2'b01);
    chk("lane_err_set", (ROWW+1)'(lane_err), (ROWW+1)'(1));
    repeat (BEATS-1) begin
      fill_rand();
      send_beat('1);
    end
    drain("lane_err_tile");

    // Random traffic with random sink stalls and gaps
    for (int n = 0; n < 48; n++) begin
      w = 0;
      while (exp_q.size() > DEPTH - 3 && w < 200) begin
        outready = 1'($urandom_range(1));
        @(posedge clk); #1;
        w++;
      end
      if (w >= 200) chk("rand_wait_timeout", (ROWW+1)'(exp_q.size()), '0);
      fill_rand();
      outready = 1'($urandom_range(1));
      send_beat('1);
      repeat ($urandom_range(2)) begin
        outready = 1'($urandom_range(1));
        @(posedge clk); #1;
      end
    end
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
